prime_seq_gen: RTL and testbench

- Sequential prime generator: the producing side of the primality check. Instead of answering "is N prime?", it emits successive primes >= a seed value.
- Each candidate is tested by iterative trial division, one divisor per clock.
- Results stream out over a valid/ready handshake.
- Feeds test benches and downstream consumers that need a prime stream.

---
 rtl/prime_seq_gen.sv | 181 ++++++++++++++++++
 tb/tb_prime_seq_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/prime_seq_gen.sv
// prime_seq_gen -- streams successive primes >= seed over a valid/ready handshake.
//
// Each candidate is tested by trial division, one divisor per clock.
// A candidate is prime once d*d exceeds it. It is composite as soon as some d
// divides it evenly.
//
// Optional build macro: PRIME_SEQ_ODD_SKIP_EN
//   When defined, only 2 and odd candidates are tried, and odd candidates are
//   divided by odd divisors only. The emitted sequence and the handshake are
//   unchanged; only the number of TEST cycles is reduced.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        one-cycle request, sampled only in IDLE
//   seed   [W]   lowest value to consider (values < 2 are treated as 2)
//   num    [CW]  number of primes to emit (0 -> immediate done)
//   prime_ready  consumer accepts prime_out this cycle
//   prime_out [W] current / last emitted prime
//   prime_valid  prime_out holds a prime awaiting acceptance
//   busy         high in every state except IDLE
//   done         one-cycle pulse when a request completes
//   ovf          sticky: ran out of W-bit candidates before num primes were
//                emitted; cleared by the next accepted start
module prime_seq_gen #(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  seed,
    input  logic [CW-1:0] num,
    input  logic          prime_ready,
    output logic [W-1:0]  prime_out,
    output logic          prime_valid,
    output logic          busy,
    output logic          done,
    output logic          ovf
);

    typedef enum logic [1:0] {IDLE, TEST, EMIT, DONE} state_t;

    localparam logic [W-1:0]  CAND_MAX = '1;
    localparam logic [W-1:0]  TWO      = W'(2);
    localparam logic [CW-1:0] ONE_REM  = CW'(1);

    state_t        state, state_nx;
    logic [W-1:0]  cand, cand_nx;
    logic [W-1:0]  d, d_nx;
    logic [CW-1:0] rem, rem_nx;
    logic [W-1:0]  prime_out_nx;
    logic          ovf_nx;

    // Candidate stepping, computed once and shared by TEST and EMIT.
    logic [W-1:0]   start_cand, start_d;
    logic [W-1:0]   adv_cand, adv_d, d_step;
    logic           adv_ovf;
    logic [2*W-1:0] d_sq;

    // Full-width square, so the prime test stays correct near 2^W-1.
    assign d_sq = (2*W)'(d) * (2*W)'(d);

`ifdef PRIME_SEQ_ODD_SKIP_EN
    always_comb begin
        if (seed < TWO)
            start_cand = TWO;
        else if (seed > TWO && !seed[0])
            start_cand = seed + W'(1);   // an even seed is at most 2^W-2, so no wrap
        else
            start_cand = seed;
        start_d  = (start_cand == TWO) ? TWO : W'(3);
        // Past 2 every candidate is odd, so stepping by 2 keeps it odd.
        adv_ovf  = (cand != TWO) && (cand >= CAND_MAX - W'(1));
        adv_cand = (cand == TWO) ? W'(3) : cand + TWO;
        adv_d    = W'(3);
        d_step   = TWO;
    end
`else
    always_comb begin
        start_cand = (seed < TWO) ? TWO : seed;
        start_d    = TWO;
        adv_ovf    = (cand == CAND_MAX);
        adv_cand   = cand + W'(1);
        adv_d      = TWO;
        d_step     = W'(1);
    end
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path through the block can leave it unassigned and infer a latch.
        state_nx     = state;
        cand_nx      = cand;
        d_nx         = d;
        rem_nx       = rem;
        prime_out_nx = prime_out;
        ovf_nx       = ovf;

        unique case (state)
            IDLE: begin
                if (start) begin
                    ovf_nx = 1'b0;
                    if (num != '0) begin
                        cand_nx  = start_cand;
                        d_nx     = start_d;
                        rem_nx   = num;
                        state_nx = TEST;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end

            TEST: begin
                if (d_sq > (2*W)'(cand)) begin
                    prime_out_nx = cand;
                    state_nx     = EMIT;
                end else if ((cand % d) == '0) begin
                    if (adv_ovf) begin
                        ovf_nx   = 1'b1;
                        state_nx = DONE;
                    end else begin
                        cand_nx = adv_cand;
                        d_nx    = adv_d;
                    end
                end else begin
                    d_nx = d + d_step;
                end
            end

            EMIT: begin
                if (prime_ready) begin
                    rem_nx = rem - ONE_REM;
                    if (rem == ONE_REM) begin
                        state_nx = DONE;
                    end else if (adv_ovf) begin
                        ovf_nx   = 1'b1;
                        state_nx = DONE;
                    end else begin
                        cand_nx  = adv_cand;
                        d_nx     = adv_d;
                        state_nx = TEST;
                    end
                end
            end

            DONE: state_nx = IDLE;

            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments, so every register
    // samples the values from before the edge, whatever order the lines are in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prime_out <= '0;
            ovf       <= 1'b0;
            // NOTE: the working registers are cleared here as well. Nothing
            // reads them before IDLE reloads them, but clearing them keeps
            // their values deterministic after reset.
            cand      <= '0;
            d         <= '0;
            rem       <= '0;
        end else begin
            state     <= state_nx;
            prime_out <= prime_out_nx;
            ovf       <= ovf_nx;
            cand      <= cand_nx;
            d         <= d_nx;
            rem       <= rem_nx;
        end
    end

    assign prime_valid = (state == EMIT);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_prime_seq_gen.sv
// tb_prime_seq_gen -- self-checking bench for prime_seq_gen, built with W=8 so
// that candidate exhaustion at 255 can be reached.
//
// The reference model lists the primes >= max(seed,2) by plain trial division
// over the integers, takes the first num of them, and expects ovf when fewer
// than num fit in 8 bits.
module tb_prime_seq_gen;

    localparam int W  = 8;
    localparam int CW = 8;
    localparam int BUDGET = 5000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  seed;
    logic [CW-1:0] num;
    logic          prime_ready;
    logic [W-1:0]  prime_out;
    logic          prime_valid;
    logic          busy;
    logic          done;
    logic          ovf;

    int n_vec = 0;
    int n_err = 0;

    prime_seq_gen #(.W(W), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .seed        (seed),
        .num         (num),
        .prime_ready (prime_ready),
        .prime_out   (prime_out),
        .prime_valid (prime_valid),
        .busy        (busy),
        .done        (done),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_prime(input int c);
        if (c < 2) return 1'b0;
        for (int k = 2; k * k <= c; k++)
            if (c % k == 0) return 1'b0;
        return 1'b1;
    endfunction

    // mode 0: ready always 1; mode 1: random ready; mode 2: ready held 0 for
    // the first 4 cycles a prime is presented, then 1.
    task automatic run_req(input int s, input int n, input int mode,
                           input bit poke_start, input bit check_lat);
        int  exp_q[$];
        bit  exp_ovf;
        int  c;
        int  idx = 0;
        int  cyc = 0;
        int  hold = 4;
        int  first_valid = -1;
        bit  got_done = 1'b0;
        bit  valid_seen = 1'b0;
        bit  prev_xfer = 1'b0;
        bit  prev_stall = 1'b0;
        bit  r;
        logic [W-1:0] prev_out = '0;

        c = (s < 2) ? 2 : s;
        while (exp_q.size() < n && c <= 255) begin
            if (is_prime(c)) exp_q.push_back(c);
            c++;
        end
        exp_ovf = (exp_q.size() < n);

        @(negedge clk);
        seed  = W'(s);
        num   = CW'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("ovf_cleared_on_start", ovf, 0);
        // Inputs other than start are only sampled with an accepted start.
        seed = W'($urandom);
        num  = CW'($urandom);

        forever begin
            if (prev_xfer) check("valid_drops_after_xfer", prime_valid, 0);
            prev_xfer = 1'b0;
            start = poke_start && (cyc == 2);
            if (done) begin
                got_done = 1'b1;
            end else if (prime_valid) begin
                valid_seen = 1'b1;
                if (first_valid < 0) first_valid = cyc;
                if (prev_stall) check("held_prime_stable", prime_out, prev_out);
                case (mode)
                    0:       r = 1'b1;
                    1:       r = 1'($urandom_range(0, 1));
                    default: begin
                        r = (hold == 0);
                        if (hold > 0) hold--;
                    end
                endcase
                prime_ready = r;
                if (r) begin
                    if (idx < exp_q.size())
                        check("prime_out", prime_out, exp_q[idx]);
                    else
                        check("unexpected_prime", idx, exp_q.size());
                    idx++;
                end
                prev_xfer  = r;
                prev_stall = !r;
                prev_out   = prime_out;
            end else begin
                prime_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (got_done || cyc >= BUDGET) break;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;

        check("done_seen", got_done, 1);
        check("prime_count", idx, exp_q.size());
        check("ovf_at_done", ovf, exp_ovf);
        if (n == 0) begin
            check("num0_done_latency", cyc, 0);
            check("num0_no_valid", valid_seen, 0);
        end
        if (check_lat) check("first_valid_latency", first_valid, 1);

        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_not_busy", busy, 0);
        check("idle_no_valid", prime_valid, 0);
        check("ovf_sticky", ovf, exp_ovf);
        if (idx > 0 && idx <= exp_q.size())
            check("prime_out_kept", prime_out, exp_q[idx-1]);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        seed = '0;
        num = '0;
        prime_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_prime_out", prime_out, 0);
        check("rst_valid", prime_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;

        // First five primes, back-to-back, with the latency check.
        run_req(2, 5, 0, 0, 1);
        run_req(10, 3, 0, 0, 0);
        run_req(13, 1, 0, 0, 0);
        run_req(0, 2, 0, 0, 0);
        // Consumer stall while 23 is presented.
        run_req(20, 2, 2, 0, 0);
        // Zero-length request, then a start pulse while busy.
        run_req(77, 0, 0, 0, 0);
        run_req(30, 4, 0, 1, 0);
        // Candidate exhaustion, then a request that clears ovf.
        run_req(250, 3, 0, 0, 0);
        run_req(2, 1, 0, 0, 0);

        // Reset in the middle of testing candidate 97.
        @(negedge clk);
        seed = 8'd97;
        num = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_prime_out", prime_out, 0);
        check("midrst_valid", prime_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ovf", ovf, 0);
        run_req(97, 1, 0, 0, 0);

        // Random seeds and counts against a random consumer.
        for (int i = 0; i < 16; i++)
            run_req($urandom_range(0, 255), $urandom_range(1, 6), 1, 1'($urandom_range(0, 1)), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
